rx_frame_guard: RTL and testbench
=================================

RX_FRAME_GUARD -- requirements
Module: rx_frame_guard

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, meaning stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter C_FIFO_DEPTH_LOG2, default 11, meaning log2 of buffer depth in words (2048).
REQ-003 SHALL have parameter C_MAX_WORDS, default 1128, meaning longest legal frame in words; must be less than 2^C_FIFO_DEPTH_LOG2.
REQ-004 SHALL have port axi_aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port axi_resetn, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports s_axis_tdata, tkeep, tuser, tvalid, tlast: inputs of widths C_DATA_WIDTH, C_DATA_WIDTH/8, 1, 1, 1; they carry the MAC receive stream, and tuser[0]=1 on the tlast beat marks a bad frame.
REQ-007 SHALL have port s_axis_tready, output, 1, constant 1 out of reset; the MAC cannot be stalled.
REQ-008 SHALL have ports m_axis_tdata, tkeep, tuser, tvalid, tlast: outputs with the same widths as the s_axis ports, carrying the filtered stream; m_axis_tuser is always 0.
REQ-009 SHALL have port m_axis_tready, input, 1, downstream backpressure.
REQ-010 SHALL have ports cnt_ok, cnt_bad, cnt_long, cnt_ovf: outputs, 32 bits each, holding saturating frame counters.

Function
REQ-011 SHALL accept one input beat on every cycle with s_axis_tvalid=1.
REQ-012 SHALL store tdata, tkeep and tlast per word in a store-and-forward RAM of 2^C_FIFO_DEPTH_LOG2 entries.
REQ-013 SHALL keep three pointers: wr_ptr (speculative), commit_ptr and rd_ptr, each C_FIFO_DEPTH_LOG2+1 bits wide and wrapping modulo 2^(C_FIFO_DEPTH_LOG2+1).
REQ-014 SHALL run a write FSM with states SYNC, IDLE, RECV and DISCARD.
REQ-015 SHALL leave reset in SYNC; in SYNC all beats are discarded and no counter changes; a beat with tlast=1 moves the FSM to IDLE.
REQ-016 SHALL, in IDLE, treat a beat with tlast=0 as the first word of a frame: write it, set the word count to 1 and go to RECV.
REQ-017 SHALL, in IDLE, treat a beat with tlast=1 as a complete single-word frame and evaluate it under REQ-020.
REQ-018 SHALL, in RECV, write each beat and increment the word count.
REQ-019 SHALL leave RECV for DISCARD, without writing the beat, if the beat would be word C_MAX_WORDS+1 (long) or the RAM is full, i.e. wr_ptr-rd_ptr = 2^C_FIFO_DEPTH_LOG2 (overflow).
REQ-020 SHALL, on an accepted tlast beat in RECV or IDLE: commit when tuser[0]=0 (commit_ptr <= wr_ptr+1, cnt_ok+1); otherwise roll back (wr_ptr <= commit_ptr, cnt_bad+1).
REQ-021 SHALL, in DISCARD, drop beats until tlast; on tlast it sets wr_ptr <= commit_ptr, increments cnt_long or cnt_ovf according to the entry cause, and returns to IDLE.
REQ-022 SHALL give long priority over overflow when both occur on the same beat, and shall ignore tuser in DISCARD.
REQ-023 SHALL treat a frame of exactly C_MAX_WORDS words as legal.
REQ-024 SHALL drive the read side from committed data only: a word is readable when rd_ptr != commit_ptr.
REQ-025 SHALL use a one-register output stage; m_axis_tvalid holds, with data stable, until m_axis_tready=1.
REQ-026 SHALL provide full throughput of one word per cycle while committed data exists and m_axis_tready=1.
REQ-027 SHALL, with the output idle, assert m_axis_tvalid with the frame's first word exactly 2 cycles after the edge that accepted the frame's tlast.
REQ-028 SHALL allow a write and a read in the same cycle; the full check uses the pre-edge rd_ptr.
REQ-029 SHALL saturate every counter at 32'hFFFFFFFF.
REQ-030 SHALL pass the stored tkeep of the last word unchanged and shall not check tkeep on non-last words.

Reset
REQ-031 SHALL, while axi_resetn=0: clear all pointers and counters, force m_axis_tvalid=0, m_axis_tlast=0 and s_axis_tready=0, and put the FSM in SYNC.
REQ-032 SHALL, after reset deasserts mid-frame, discard the tail of that frame without counting it (SYNC).
REQ-033 SHALL lose any uncommitted or partially read data at reset.

Verification
REQ-034 SHALL pass this test: 5-word frame, tdata=64'hDEADBEEFAFFEDEAD, tkeep=8'hFF, tready=1 -> 5 words out, tlast on the 5th, first word 2 cycles after tlast, cnt_ok=1.
REQ-035 SHALL pass this test: 1128-word frame, then a 1389-word frame (tdata ...0003) -> first frame passed complete; second produces no output, cnt_long=1, wr_ptr equals commit_ptr afterwards.
REQ-036 SHALL pass this test: 5-word frame ending with tkeep=8'h0F, then an identical frame with tuser=1 on tlast -> first output with last tkeep=8'h0F; second absent, cnt_bad=1.
REQ-037 SHALL pass this test: m_axis_tready=0 while three 1000-word frames arrive (depth 2048) -> frames 1 and 2 stored, frame 3 dropped, cnt_ovf=1; releasing tready yields exactly 2000 words.
REQ-038 SHALL pass this test: reset asserted in word 3 of a 10-word frame, released at word 6 -> words 6 to 10 produce no output and all counters stay 0; the next 4-word frame passes with cnt_ok=1.
REQ-039 SHALL pass this test: a single-word frame (tlast on the first beat) with tready toggling every cycle -> exactly one output beat with tlast=1, data held stable while tready=0.

Source files
------------

// File: rtl/rx_frame_guard.sv
// Store-and-forward receive filter: buffers each MAC frame, forwards only
// complete good frames, and drops bad, over-long or overflowing frames.
module rx_frame_guard #(
  parameter int C_DATA_WIDTH      = 64,
  parameter int C_FIFO_DEPTH_LOG2 = 11,
  parameter int C_MAX_WORDS       = 1128
) (
  input  logic                      axi_aclk,
  input  logic                      axi_resetn,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [31:0]               cnt_ok,
  output logic [31:0]               cnt_bad,
  output logic [31:0]               cnt_long,
  output logic [31:0]               cnt_ovf
);

  localparam int KW    = C_DATA_WIDTH / 8;
  localparam int AW    = C_FIFO_DEPTH_LOG2;
  localparam int PW    = C_FIFO_DEPTH_LOG2 + 1;
  localparam int MW    = C_DATA_WIDTH + KW + 1;
  localparam int DEPTH = 1 << C_FIFO_DEPTH_LOG2;
  localparam logic [PW-1:0] C_FULL_DIFF = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] C_MAX_CNT   = PW'(C_MAX_WORDS);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RECV    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_commit_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_word_cnt;
  logic          r_cause_long;
  logic          r_s_tready;
  logic [31:0]   r_cnt_ok;
  logic [31:0]   r_cnt_bad;
  logic [31:0]   r_cnt_long;
  logic [31:0]   r_cnt_ovf;

  logic [MW-1:0] r_mem [DEPTH];
  logic [MW-1:0] r_s1_word;
  logic          r_s1_valid;
  logic          r_m_valid;
  logic [C_DATA_WIDTH-1:0] r_m_data;
  logic [KW-1:0] r_m_keep;
  logic          r_m_last;

  logic          w_full;
  logic          w_long;
  logic          w_wr_en;
  logic          w_commit;
  logic          w_rollback;
  logic          w_cnt_first;
  logic          w_cnt_inc;
  logic          w_cause_set;
  logic          w_cause_long_nxt;
  logic          w_inc_ok;
  logic          w_inc_bad;
  logic          w_inc_long;
  logic          w_inc_ovf;
  logic          w_rd_avail;
  logic          w_out_ready;
  logic          w_s1_ready;
  logic          w_rd_en;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  // Full compares against the pre-edge read pointer, so a same-cycle read does not free space early.
  assign w_full    = ((r_wr_ptr - r_rd_ptr) == C_FULL_DIFF);
  assign w_long    = (r_word_cnt == C_MAX_CNT);
  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // Write FSM state register
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write FSM next-state and per-beat write/commit/count decisions
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_en          = 1'b0;
    w_commit         = 1'b0;
    w_rollback       = 1'b0;
    w_cnt_first      = 1'b0;
    w_cnt_inc        = 1'b0;
    w_cause_set      = 1'b0;
    w_cause_long_nxt = 1'b0;
    w_inc_ok         = 1'b0;
    w_inc_bad        = 1'b0;
    w_inc_long       = 1'b0;
    w_inc_ovf        = 1'b0;
    if (s_axis_tvalid) begin
      case (r_state)
        ST_SYNC: begin
          if (s_axis_tlast) w_state_nxt = ST_IDLE;
          else              w_state_nxt = ST_SYNC;
        end
        ST_IDLE: begin
          // A full buffer at frame start is treated as overflow of the new frame.
          if (w_full) begin
            if (s_axis_tlast) begin
              w_inc_ovf = 1'b1;
            end else begin
              w_cause_set = 1'b1;
              w_state_nxt = ST_DISCARD;
            end
          end else if (!s_axis_tlast) begin
            w_wr_en     = 1'b1;
            w_cnt_first = 1'b1;
            w_state_nxt = ST_RECV;
          end else if (!s_axis_tuser) begin
            w_wr_en  = 1'b1;
            w_commit = 1'b1;
            w_inc_ok = 1'b1;
          end else begin
            w_inc_bad = 1'b1;
          end
        end
        ST_RECV: begin
          if (w_long) begin
            w_cause_set      = 1'b1;
            w_cause_long_nxt = 1'b1;
            w_state_nxt      = ST_DISCARD;
          end else if (w_full) begin
            w_cause_set = 1'b1;
            w_state_nxt = ST_DISCARD;
          end else if (!s_axis_tlast) begin
            w_wr_en   = 1'b1;
            w_cnt_inc = 1'b1;
          end else if (!s_axis_tuser) begin
            w_wr_en     = 1'b1;
            w_commit    = 1'b1;
            w_inc_ok    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_rollback  = 1'b1;
            w_inc_bad   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (s_axis_tlast) begin
            w_rollback  = 1'b1;
            w_inc_long  = r_cause_long;
            w_inc_ovf   = !r_cause_long;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end
        default: w_state_nxt = ST_SYNC;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Write-side pointers, frame word count, discard cause and MAC ready
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_word_cnt   <= '0;
      r_cause_long <= 1'b0;
      r_s_tready   <= 1'b0;
    end else begin
      r_s_tready <= 1'b1;
      if (w_rollback)   r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_commit)     r_commit_ptr <= r_wr_ptr + 1'b1;
      if (w_cnt_first)    r_word_cnt <= {{(PW-1){1'b0}}, 1'b1};
      else if (w_cnt_inc) r_word_cnt <= r_word_cnt + 1'b1;
      if (w_cause_set)  r_cause_long <= w_cause_long_nxt;
    end
  end

  // Saturating frame counters
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_cnt_ok   <= 32'd0;
      r_cnt_bad  <= 32'd0;
      r_cnt_long <= 32'd0;
      r_cnt_ovf  <= 32'd0;
    end else begin
      if (w_inc_ok)   r_cnt_ok   <= sat_inc(r_cnt_ok);
      if (w_inc_bad)  r_cnt_bad  <= sat_inc(r_cnt_bad);
      if (w_inc_long) r_cnt_long <= sat_inc(r_cnt_long);
      if (w_inc_ovf)  r_cnt_ovf  <= sat_inc(r_cnt_ovf);
    end
  end

  // Buffer RAM write port
  always_ff @(posedge axi_aclk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Read pipeline: registered RAM read stage feeding the output register, both
  // advancing whenever the output is empty or being taken.
  assign w_rd_avail  = (r_rd_ptr != r_commit_ptr);
  assign w_out_ready = !r_m_valid || m_axis_tready;
  assign w_s1_ready  = !r_s1_valid || w_out_ready;
  assign w_rd_en     = w_rd_avail && w_s1_ready;

  // Buffer RAM synchronous read port
  always_ff @(posedge axi_aclk) begin
    if (w_rd_en) r_s1_word <= r_mem[w_rd_addr];
  end

  // Read pointer, stage valids and output register
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_rd_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_keep   <= '0;
      r_m_last   <= 1'b0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_en)          r_s1_valid <= 1'b1;
      else if (w_out_ready) r_s1_valid <= 1'b0;
      if (w_out_ready) begin
        r_m_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_m_data <= r_s1_word[C_DATA_WIDTH-1:0];
          r_m_keep <= r_s1_word[C_DATA_WIDTH +: KW];
          r_m_last <= r_s1_word[MW-1];
        end
      end
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tuser  = 1'b0;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign cnt_ok        = r_cnt_ok;
  assign cnt_bad       = r_cnt_bad;
  assign cnt_long      = r_cnt_long;
  assign cnt_ovf       = r_cnt_ovf;

endmodule

// File: tb/tb_rx_frame_guard.sv
// Directed bench for rx_frame_guard: each task drives one scenario and
// checks outputs against hand-computed expectations.
module tb_rx_frame_guard;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tuser;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tuser;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [31:0] c_ok, c_bad, c_long, c_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc_cyc = 0;

  logic [63:0] q_data [$];
  logic [7:0]  q_keep [$];
  logic        q_last [$];
  logic        q_user [$];
  int          q_cyc  [$];

  rx_frame_guard dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .cnt_ok        (c_ok),
    .cnt_bad       (c_bad),
    .cnt_long      (c_long),
    .cnt_ovf       (c_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer; inputs change just after posedge so negedge is stable.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_keep.push_back(m_tkeep);
      q_last.push_back(m_tlast);
      q_user.push_back(m_tuser);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete(); q_cyc.delete();
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_words(input int n, input int limit);
    for (int i = 0; i < limit && q_data.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
    total++; if ({c_ok, c_bad, c_long, c_ovf} !== 128'd0) begin bad++; $display("FAIL rst_counters got=%h exp=0", {c_ok, c_bad, c_long, c_ovf}); end
    rst_n = 1'b1;
    idle(1);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL run_tready got=%b exp=1", s_tready); end
    clear_q();
    // Stream is joined mid-frame: both beats belong to an unknown frame and are dropped.
    beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
    beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b1);
    idle(8);
    total++; if (q_data.size() !== 0) begin bad++; $display("FAIL sync_output got=%0d exp=0", q_data.size()); end
    total++; if (c_ok !== 32'd0 || c_bad !== 32'd0) begin bad++; $display("FAIL sync_counters ok=%0d bad=%0d exp=0", c_ok, c_bad); end
  endtask

  task automatic test_basic();
    int errs;
    clear_q();
    for (int i = 0; i < 5; i++) beat(64'hDEAD_BEEF_AFFE_DEAD, 8'hFF, 1'b0, (i == 4));
    wait_words(5, 30);
    idle(4);
    total++; if (q_data.size() !== 5) begin bad++; $display("FAIL basic_count got=%0d exp=5", q_data.size()); end
    if (q_data.size() == 5) begin
      errs = 0;
      for (int i = 0; i < 5; i++) begin
        if (q_data[i] !== 64'hDEAD_BEEF_AFFE_DEAD || q_keep[i] !== 8'hFF || q_user[i] !== 1'b0) errs++;
        if (q_last[i] !== (i == 4)) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL basic_words errors=%0d exp=0", errs); end
      total++; if (q_cyc[0] !== last_acc_cyc + 2) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", q_cyc[0] - last_acc_cyc, 2); end
      total++; if (q_cyc[4] !== q_cyc[0] + 4) begin bad++; $display("FAIL basic_throughput got=%0d exp=%0d", q_cyc[4] - q_cyc[0], 4); end
    end
    total++; if (c_ok !== 32'd1) begin bad++; $display("FAIL basic_cnt_ok got=%0d exp=1", c_ok); end
  endtask

  task automatic test_long();
    int errs;
    clear_q();
    for (int i = 0; i < 1128; i++) beat({32'hA5A5_0002, 32'(i)}, 8'hFF, 1'b0, (i == 1127));
    for (int i = 0; i < 1389; i++) beat(64'h0000_0000_0000_0003, 8'hFF, 1'b0, (i == 1388));
    wait_words(1128, 3000);
    idle(10);
    total++; if (q_data.size() !== 1128) begin bad++; $display("FAIL long_count got=%0d exp=1128", q_data.size()); end
    errs = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== {32'hA5A5_0002, 32'(i)}) errs++;
      if (q_last[i] !== (i == 1127)) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL long_words errors=%0d exp=0", errs); end
    total++; if (c_long !== 32'd1) begin bad++; $display("FAIL long_cnt_long got=%0d exp=1", c_long); end
    total++; if (c_ok !== 32'd2) begin bad++; $display("FAIL long_cnt_ok got=%0d exp=2", c_ok); end
    total++; if (dut.r_wr_ptr !== dut.r_commit_ptr) begin bad++; $display("FAIL long_ptrs wr=%0d commit=%0d", dut.r_wr_ptr, dut.r_commit_ptr); end
  endtask

  task automatic test_bad_frame();
    clear_q();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 5; i++)
        beat(64'h0000_0000_0000_0100 + 64'(i), (i == 4) ? 8'h0F : 8'hFF, (f == 1) && (i == 4), (i == 4));
    wait_words(5, 40);
    idle(10);
    total++; if (q_data.size() !== 5) begin bad++; $display("FAIL bad_count got=%0d exp=5", q_data.size()); end
    if (q_data.size() == 5) begin
      total++; if (q_keep[4] !== 8'h0F) begin bad++; $display("FAIL bad_last_keep got=%h exp=0f", q_keep[4]); end
      total++; if (q_data[4] !== 64'h104 || q_last[4] !== 1'b1) begin bad++; $display("FAIL bad_last_word got=%h/%b exp=104/1", q_data[4], q_last[4]); end
    end
    total++; if (c_bad !== 32'd1) begin bad++; $display("FAIL bad_cnt_bad got=%0d exp=1", c_bad); end
    total++; if (c_ok !== 32'd3) begin bad++; $display("FAIL bad_cnt_ok got=%0d exp=3", c_ok); end
  endtask

  task automatic test_overflow();
    int errs;
    int nlast;
    clear_q();
    m_tready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 1000; i++) beat({32'(f), 32'(i)}, 8'hFF, 1'b0, (i == 999));
    idle(5);
    total++; if (c_ovf !== 32'd1) begin bad++; $display("FAIL ovf_cnt_ovf got=%0d exp=1", c_ovf); end
    total++; if (c_ok !== 32'd5) begin bad++; $display("FAIL ovf_cnt_ok got=%0d exp=5", c_ok); end
    total++; if (q_data.size() !== 0) begin bad++; $display("FAIL ovf_stalled got=%0d exp=0", q_data.size()); end
    m_tready = 1'b1;
    wait_words(2000, 2200);
    idle(10);
    total++; if (q_data.size() !== 2000) begin bad++; $display("FAIL ovf_count got=%0d exp=2000", q_data.size()); end
    errs = 0;
    nlast = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== {32'(i / 1000), 32'(i % 1000)}) errs++;
      if (q_last[i]) nlast++;
    end
    total++; if (errs !== 0 || nlast !== 2) begin bad++; $display("FAIL ovf_words errors=%0d lasts=%0d exp=0/2", errs, nlast); end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    beat(64'h51, 8'hFF, 1'b0, 1'b0);
    beat(64'h52, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    beat(64'h53, 8'hFF, 1'b0, 1'b0);
    total++; if ({c_ok, c_bad, c_long, c_ovf} !== 128'd0) begin bad++; $display("FAIL mid_rst_counters got=%h exp=0", {c_ok, c_bad, c_long, c_ovf}); end
    beat(64'h54, 8'hFF, 1'b0, 1'b0);
    beat(64'h55, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 6; i <= 10; i++) beat(64'h50 + 64'(i), 8'hFF, 1'b0, (i == 10));
    idle(10);
    total++; if (q_data.size() !== 0) begin bad++; $display("FAIL mid_tail_output got=%0d exp=0", q_data.size()); end
    total++; if ({c_ok, c_bad, c_long, c_ovf} !== 128'd0) begin bad++; $display("FAIL mid_tail_counters got=%h exp=0", {c_ok, c_bad, c_long, c_ovf}); end
    for (int i = 0; i < 4; i++) beat(64'h60 + 64'(i), 8'hFF, 1'b0, (i == 3));
    wait_words(4, 30);
    idle(4);
    total++; if (q_data.size() !== 4) begin bad++; $display("FAIL mid_next_count got=%0d exp=4", q_data.size()); end
    if (q_data.size() == 4) begin
      total++; if (q_data[0] !== 64'h60 || q_data[3] !== 64'h63 || q_last[3] !== 1'b1) begin bad++; $display("FAIL mid_next_words got=%h..%h exp=60..63", q_data[0], q_data[3]); end
    end
    total++; if (c_ok !== 32'd1) begin bad++; $display("FAIL mid_cnt_ok got=%0d exp=1", c_ok); end
  endtask

  task automatic test_single_toggle();
    int held;
    int unstable;
    clear_q();
    held = 0;
    unstable = 0;
    m_tready = 1'b0;
    beat(64'hCAFE_F00D_1234_5678, 8'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      m_tready = (i % 2 == 1);
      @(negedge clk);
      if (m_tvalid && !m_tready) begin
        held++;
        if (m_tdata !== 64'hCAFE_F00D_1234_5678 || m_tlast !== 1'b1 || m_tkeep !== 8'h3F) unstable++;
      end
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    idle(4);
    total++; if (q_data.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", q_data.size()); end
    if (q_data.size() == 1) begin
      total++; if (q_data[0] !== 64'hCAFE_F00D_1234_5678 || q_last[0] !== 1'b1 || q_keep[0] !== 8'h3F) begin bad++; $display("FAIL single_word got=%h/%h/%b exp=cafef00d12345678/3f/1", q_data[0], q_keep[0], q_last[0]); end
    end
    total++; if (held < 1 || unstable !== 0) begin bad++; $display("FAIL single_hold held=%0d unstable=%0d exp=>=1/0", held, unstable); end
    total++; if (c_ok !== 32'd2) begin bad++; $display("FAIL single_cnt_ok got=%0d exp=2", c_ok); end
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = 64'd0;
    s_tkeep  = 8'd0;
    s_tuser  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    test_reset();
    test_basic();
    test_long();
    test_bad_frame();
    test_overflow();
    test_reset_midframe();
    test_single_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
